// File: rtl/demux_int.sv
// Two-port dispatcher: routes tagged 32-bit words into per-port FIFOs and
// presents each head until its consumer acknowledges it. Sticky error on acks to an empty port.
module demux_int #(
    parameter int DEPTH = 4,
    parameter int LW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [0:31]   in_data,
    input  logic          in_valid,
    input  logic          in_dest,
    output logic          out_ready,
    output logic [0:31]   out_data1,
    output logic          out_valid1,
    input  logic          in_ack1,
    output logic [0:31]   out_data2,
    output logic          out_valid2,
    input  logic          in_ack2,
    output logic [LW-1:0] out_level1,
    output logic [LW-1:0] out_level2,
    output logic          out_err
);
    localparam int AW = $clog2(DEPTH);

    logic          w_ack   [2];
    logic          w_full  [2];
    logic          w_valid [2];
    logic          w_bad   [2];
    logic [0:31]   w_data  [2];
    logic [LW-1:0] w_level [2];
    logic          r_err;

    assign w_ack[0] = in_ack1;
    assign w_ack[1] = in_ack2;

    // Ready looks only at the targeted port's level; a same-cycle pop does not help.
    assign out_ready = !w_full[in_dest];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [0:31]   r_mem [DEPTH];
            logic [AW-1:0] r_wptr;
            logic [AW-1:0] r_rptr;
            logic [LW-1:0] r_level;
            logic          w_push;
            logic          w_pop;

            assign w_full[gi]  = (r_level == LW'(DEPTH));
            assign w_valid[gi] = (r_level != '0);
            assign w_bad[gi]   = w_ack[gi] && !w_valid[gi];
            assign w_push      = in_valid && !w_full[gi] && (in_dest == 1'(gi));
            assign w_pop       = w_ack[gi] && w_valid[gi];
            assign w_data[gi]  = w_valid[gi] ? r_mem[r_rptr] : '0;
            assign w_level[gi] = r_level;

            // Storage carries no reset; the level alone decides what is valid.
            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_mem[r_wptr] <= in_data;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_level <= '0;
                end else begin
                    if (w_push) begin
                        r_wptr <= r_wptr + AW'(1);
                    end
                    if (w_pop) begin
                        r_rptr <= r_rptr + AW'(1);
                    end
                    case ({w_push, w_pop})
                        2'b10:   r_level <= r_level + LW'(1);
                        2'b01:   r_level <= r_level - LW'(1);
                        default: r_level <= r_level;
                    endcase
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_bad[0] || w_bad[1]) begin
            r_err <= 1'b1;
        end
    end

    assign out_data1  = w_data[0];
    assign out_valid1 = w_valid[0];
    assign out_level1 = w_level[0];
    assign out_data2  = w_data[1];
    assign out_valid2 = w_valid[1];
    assign out_level2 = w_level[1];
    assign out_err    = r_err;

endmodule

// File: tb/tb_demux_int.sv
// Self-checking bench for demux_int: directed test-plan scenarios followed by
// random traffic, all checked every cycle against a queue-based model.
module tb_demux_int;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic          clk;
    logic          rst_n;
    logic [0:31]   in_data;
    logic          in_valid;
    logic          in_dest;
    logic          out_ready;
    logic [0:31]   out_data1;
    logic          out_valid1;
    logic          in_ack1;
    logic [0:31]   out_data2;
    logic          out_valid2;
    logic          in_ack2;
    logic [LW-1:0] out_level1;
    logic [LW-1:0] out_level2;
    logic          out_err;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: one queue of words per port plus a sticky error flag.
    logic [31:0] q1[$];
    logic [31:0] q2[$];
    logic        m_err;

    demux_int #(.DEPTH(DEPTH), .LW(LW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_dest    (in_dest),
        .out_ready  (out_ready),
        .out_data1  (out_data1),
        .out_valid1 (out_valid1),
        .in_ack1    (in_ack1),
        .out_data2  (out_data2),
        .out_valid2 (out_valid2),
        .in_ack2    (in_ack2),
        .out_level1 (out_level1),
        .out_level2 (out_level2),
        .out_err    (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        int sz;
        sz = in_dest ? q2.size() : q1.size();
        check("ready",  32'(out_ready),  32'(sz < DEPTH));
        check("valid1", 32'(out_valid1), 32'(q1.size() > 0));
        check("valid2", 32'(out_valid2), 32'(q2.size() > 0));
        check("data1",  out_data1, (q1.size() > 0) ? q1[0] : 32'h0);
        check("data2",  out_data2, (q2.size() > 0) ? q2[0] : 32'h0);
        check("level1", 32'(out_level1), 32'(q1.size()));
        check("level2", 32'(out_level2), 32'(q2.size()));
        check("err",    32'(out_err),    32'(m_err));
    endtask

    // One clock cycle: drive inputs, check against the model, advance the model, cross the edge.
    task automatic step(input logic v, input logic d, input logic [31:0] dat,
                        input logic a1, input logic a2);
        logic push1, push2, pop1, pop2;
        in_valid = v;
        in_dest  = d;
        in_data  = dat;
        in_ack1  = a1;
        in_ack2  = a2;
        #1;
        check_model();
        push1 = v && !d && (q1.size() < DEPTH);
        push2 = v &&  d && (q2.size() < DEPTH);
        pop1  = a1 && (q1.size() > 0);
        pop2  = a2 && (q2.size() > 0);
        if ((a1 && q1.size() == 0) || (a2 && q2.size() == 0)) m_err = 1'b1;
        if (pop1) void'(q1.pop_front());
        if (pop2) void'(q2.pop_front());
        if (push1) q1.push_back(dat);
        if (push2) q2.push_back(dat);
        $display("cyc v=%0d d=%0d data=%h ack=%0d%0d -> lvl=%0d/%0d err=%0d",
                 v, d, dat, a1, a2, q1.size(), q2.size(), m_err);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_dest = 1'b0; in_data = '0; in_ack1 = 1'b0; in_ack2 = 1'b0;
    endtask

    initial begin
        idle();
        m_err = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        // Reset state
        check("rst_valid1", 32'(out_valid1), 32'd0);
        check("rst_valid2", 32'(out_valid2), 32'd0);
        check("rst_data1",  out_data1, 32'd0);
        check("rst_data2",  out_data2, 32'd0);
        check("rst_level1", 32'(out_level1), 32'd0);
        check("rst_level2", 32'(out_level2), 32'd0);
        check("rst_err",    32'(out_err), 32'd0);
        check("rst_ready",  32'(out_ready), 32'd1);
        @(posedge clk);
        #1;

        // Basic route
        step(1'b1, 1'b0, 32'hA5A5_0001, 1'b0, 1'b0);
        check("route_d1", out_data1, 32'hA5A5_0001);
        step(1'b1, 1'b1, 32'h5A5A_0002, 1'b0, 1'b0);
        check("route_d2", out_data2, 32'h5A5A_0002);
        check("route_lv", {16'(out_level1), 16'(out_level2)}, {16'd1, 16'd1});
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("route_drop", {31'd0, out_valid1 | out_valid2}, 32'd0);

        // Full and wrap on port 1
        for (int k = 1; k <= 4; k++) step(1'b1, 1'b0, 32'(k), 1'b0, 1'b0);
        check("full_ready", 32'(out_ready), 32'd0);
        check("full_level", 32'(out_level1), 32'd4);
        step(1'b1, 1'b0, 32'd5, 1'b0, 1'b0);
        check("full_hold", 32'(out_level1), 32'd4);
        check("pop_at_full_head", out_data1, 32'd1);
        step(1'b1, 1'b0, 32'd5, 1'b1, 1'b0);
        check("pop_only_at_full", 32'(out_level1), 32'd3);
        step(1'b1, 1'b0, 32'd5, 1'b0, 1'b0);
        check("word5_in", 32'(out_level1), 32'd4);
        for (int k = 2; k <= 3; k++) begin
            check("order", out_data1, 32'(k));
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        end
        // level1 == 2: simultaneous push and pop
        step(1'b1, 1'b0, 32'd6, 1'b1, 1'b0);
        check("pp_level", 32'(out_level1), 32'd2);
        check("pp_head",  out_data1, 32'd5);
        for (int k = 5; k <= 6; k++) begin
            check("order_wrap", out_data1, 32'(k));
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        end

        // Illegal ack on empty port 2
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("err_set", 32'(out_err), 32'd1);
        step(1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
        check("err_keep", 32'(out_err), 32'd1);
        check("after_err_d2", out_data2, 32'h1234_5678);

        // Reset mid-traffic: level1=3, level2=2
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'h100 + 32'(k), 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
        check("pre_rst_lv", {16'(out_level1), 16'(out_level2)}, {16'd3, 16'd2});
        idle();
        #1;
        rst_n = 1'b0;
        #1;
        q1.delete();
        q2.delete();
        m_err = 1'b0;
        check("arst_level1", 32'(out_level1), 32'd0);
        check("arst_level2", 32'(out_level2), 32'd0);
        check("arst_valid",  {31'd0, out_valid1 | out_valid2}, 32'd0);
        check("arst_err",    32'(out_err), 32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check("post_rst_d2", out_data2, 32'hDEAD_BEEF);
        check("post_rst_l2", 32'(out_level2), 32'd1);

        // Random traffic; acks biased so illegal ones are occasional
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom), $urandom,
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        end

        idle();
        #1;
        check_model();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/demux_int.md
# demux_int

Two-port dispatcher that drives the request side feeding the two-input response mux. One 32-bit source issues words tagged with a destination bit. The block queues each word in a per-port FIFO and presents it on that port until the port consumer acknowledges it. It gives the sender backpressure through a single ready line and flags protocol misuse through a sticky error bit.

## Interface
- DEPTH, 4, entries per port FIFO; must be a power of 2, ≥2.
- LW, 3, width of level outputs; must equal log2(DEPTH)+1.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  [0:31]  word from sender.
- in_valid  in  1  sender offers in_data this cycle.
- in_dest  in  1  destination: 0 → port 1, 1 → port 2.
- out_ready  out  1  targeted FIFO can accept; combinational: !full[in_dest].
- out_data1  out  [0:31]  head word of port-1 FIFO; 32'b0 when out_valid1=0.
- out_valid1  out  1  port-1 FIFO non-empty.
- in_ack1  in  1  port-1 consumer pops head.
- out_data2  out  [0:31]  as out_data1, port 2.
- out_valid2  out  1  as out_valid1, port 2.
- in_ack2  in  1  as in_ack1, port 2.
- out_level1  out  [LW-1:0]  port-1 occupancy, 0..DEPTH.
- out_level2  out  [LW-1:0]  port-2 occupancy, 0..DEPTH.
- out_err  out  1  sticky protocol error.

## Operation
- Push: when in_valid && out_ready at an edge, write in_data into FIFO[in_dest] at its write pointer. Increment that write pointer mod DEPTH and that level by 1.
- Pop, per port N: when in_ackN && out_validN at an edge, advance read pointer N mod DEPTH and decrement level N.
- Same-port push and pop in one cycle: both occur and the level is unchanged. This is legal only when not full, because out_ready ignores a same-cycle pop.
- Pushes to one port and pops on the other are fully independent. Both ports can pop in the same cycle.
- Full condition: levelN == DEPTH. Empty condition: levelN == 0. Pointers wrap silently; the levels disambiguate full from empty.
- in_valid with the target full: no write and no state change. The sender must hold the word.
- in_dest and in_data are sampled only on an accepted push. in_dest may change freely while out_ready=0.
- Error: out_err sets on any edge where in_ackN=1 and out_validN=0, for either port. It stays set until reset. An illegal ack has no other effect.
- out_dataN is combinational from the storage at read pointer N, gated to 32'b0 when the FIFO is empty.
- There is no FSM beyond the per-port pointer/level state. Each port's state behaves as an EMPTY / PARTIAL / FULL machine driven by push and pop.

## Timing
- Reset (rst_n=0, asynchronous): all pointers and levels go to 0, out_err=0, out_valid1=out_valid2=0, and out_data1=out_data2=32'b0. out_ready reads 1. Storage contents are don't-care.
- Reset asserted mid-traffic discards all queued words immediately, without waiting for a clock edge.
- Reset deassertion is synchronised by the user. The first push is accepted on the first edge with rst_n=1.
- Latency: a word accepted at edge k appears on out_dataN with out_validN=1 after edge k, provided the FIFO was empty. There is no combinational in→out path.
- Pop: after the edge where an ack is accepted, the next head word (or 0 / valid=0) appears.
- out_ready responds to in_dest combinationally within the same cycle, and to level changes after the edge.
- Sustained throughput is 1 push and 1 pop per port per cycle when the FIFO is neither full nor empty.

## Test plan
- Reset check: assert rst_n=0 for 2 cycles, then release. Required: out_valid1/2=0, out_data1/2=0, out_level1/2=0, out_err=0, out_ready=1.
- Basic route: push 32'hA5A5_0001 with dest 0, then 32'h5A5A_0002 with dest 1. Required: out_data1=A5A50001 one cycle after the first push, and out_data2=5A5A0002 one cycle after the second. Levels show 1/1. Ack both; both valids drop the next cycle.
- Full and wrap: push 5 words (1..5) to port 1 with no ack. Required: out_ready=0 after the 4th push, word 5 held, level1=4. Ack once; word 5 is accepted the next cycle. Pop all; the order is 1,2,3,4,5 across the pointer wrap.
- Simultaneous push and pop: with level1=2, push to port 1 and ack1 on the same edge. Required: level1 stays 2 and the head advances. With level1=4, the same stimulus gives pop only, because out_ready=0.
- Illegal ack: with port 2 empty, pulse in_ack2. Required: out_err=1 from the next cycle and it persists. Levels and pointers are unchanged, and subsequent traffic is unaffected.
- Reset mid-traffic: with level1=3 and level2=2, pulse rst_n low asynchronously between edges. Required: valids, levels and err clear immediately. After release, pushing 32'hDEAD_BEEF to port 2 gives out_data2=DEADBEEF with level2=1.
